// File: rtl/mem_arbiter_if.sv
// Bus bundle between the caches, the memory model and mem_arbiter.
// The slave modport is the arbiter's view; master is the cache/memory side.
interface mem_arbiter_if;
  logic        i_req;
  logic [15:0] i_addr;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] mem_rdata;
  logic        mem_data_valid;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] fill_data;
  logic        i_data_valid;
  logic        d_data_valid;
  logic [2:0]  fill_word;
  logic        i_done;
  logic        d_done;
  logic        i_stall;
  logic        d_stall;

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_data_valid,
    output mem_en, mem_wr, mem_addr, mem_wdata, fill_data, i_data_valid,
           d_data_valid, fill_word, i_done, d_done, i_stall, d_stall
  );

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_data_valid,
    input  mem_en, mem_wr, mem_addr, mem_wdata, fill_data, i_data_valid,
           d_data_valid, fill_word, i_done, d_done, i_stall, d_stall
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one pipelined memory port between I-cache fills
// and D-cache fills/stores; fills are 8 back-to-back reads of an aligned block.
module mem_arbiter #(
  parameter int MEM_LATENCY     = 4,
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, WRITE = 2'd2} state_t;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  if (WORDS_PER_BLOCK != 8 || MEM_LATENCY < 1) begin : g_param_check
    $error("mem_arbiter: WORDS_PER_BLOCK must be 8 and MEM_LATENCY at least 1");
  end

  state_t      state, state_nxt;
  logic        owner, owner_nxt;
  logic        last_owner, last_owner_nxt;
  logic [11:0] base, base_nxt;
  logic [3:0]  issue_cnt, issue_cnt_nxt;
  logic [2:0]  ret_cnt, ret_cnt_nxt;
  logic        grant_d;
  logic        unused_ok;

  // Miss offset within the block never matters: fills always start at word 0.
  assign unused_ok = &{1'b0, bus.i_addr[3:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= OWN_I;
      last_owner <= OWN_I;
      issue_cnt  <= '0;
      ret_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      issue_cnt  <= issue_cnt_nxt;
      ret_cnt    <= ret_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    base <= base_nxt;
  end

  always_comb begin
    state_nxt        = state;
    owner_nxt        = owner;
    last_owner_nxt   = last_owner;
    base_nxt         = base;
    issue_cnt_nxt    = issue_cnt;
    ret_cnt_nxt      = ret_cnt;
    grant_d          = 1'b0;
    bus.mem_en       = 1'b0;
    bus.mem_wr       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    bus.i_data_valid = 1'b0;
    bus.d_data_valid = 1'b0;
    bus.fill_word    = '0;
    bus.i_done       = 1'b0;
    bus.d_done       = 1'b0;

    case (state)
      IDLE: begin
        // On a tie, D wins unless it was the last one served.
        grant_d = bus.d_req & (~bus.i_req | (last_owner == OWN_I));
        if (bus.i_req || bus.d_req) begin
          owner_nxt      = grant_d;
          last_owner_nxt = grant_d;
          base_nxt       = grant_d ? bus.d_addr[15:4] : bus.i_addr[15:4];
          issue_cnt_nxt  = '0;
          ret_cnt_nxt    = '0;
          state_nxt      = (grant_d && bus.d_wr) ? WRITE : FILL;
        end
      end

      FILL: begin
        if (issue_cnt < 4'(WORDS_PER_BLOCK)) begin
          bus.mem_en    = 1'b1;
          bus.mem_addr  = {base, issue_cnt[2:0], 1'b0};
          issue_cnt_nxt = issue_cnt + 4'd1;
        end
        // Returns come back in issue order, so ret_cnt is the word index.
        if (bus.mem_data_valid) begin
          bus.i_data_valid = (owner == OWN_I);
          bus.d_data_valid = (owner == OWN_D);
          bus.fill_word    = ret_cnt;
          if (ret_cnt == 3'd7) begin
            bus.i_done    = (owner == OWN_I);
            bus.d_done    = (owner == OWN_D);
            issue_cnt_nxt = '0;
            ret_cnt_nxt   = '0;
            state_nxt     = IDLE;
          end else begin
            ret_cnt_nxt = ret_cnt + 3'd1;
          end
        end
      end

      WRITE: begin
        bus.mem_en    = 1'b1;
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = bus.d_addr;
        bus.mem_wdata = bus.d_wdata;
        bus.d_done    = 1'b1;
        state_nxt     = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign bus.fill_data = bus.mem_rdata;
  // Stalls are forced low while reset is held, like every other control output.
  assign bus.i_stall   = rst & bus.i_req & ~bus.i_done;
  assign bus.d_stall   = rst & bus.d_req & ~bus.d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a MEM_LATENCY-deep pipelined memory model.
module tb_mem_arbiter;

  localparam int LAT = 4;

  logic clk;
  logic rst;
  logic spur;
  logic st_done;
  int   total;
  int   bad;

  mem_arbiter_if bus ();

  mem_arbiter #(.MEM_LATENCY(LAT), .WORDS_PER_BLOCK(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: default content is a fixed pattern of the byte address.
  logic [15:0] mem_arr [0:32767];
  logic        wflag   [0:32767];
  logic        pv      [LAT];
  logic [15:0] pd      [LAT];

  function automatic logic [15:0] pattern(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) pv[i] <= 1'b0;
    end else begin
      pv[0] <= bus.mem_en & ~bus.mem_wr;
      pd[0] <= (wflag[bus.mem_addr[15:1]] === 1'b1) ? mem_arr[bus.mem_addr[15:1]]
                                                     : pattern(bus.mem_addr);
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
      if (bus.mem_en && bus.mem_wr) begin
        mem_arr[bus.mem_addr[15:1]] <= bus.mem_wdata;
        wflag[bus.mem_addr[15:1]]   <= 1'b1;
      end
    end
  end

  assign bus.mem_data_valid = pv[LAT-1] | spur;
  assign bus.mem_rdata      = spur ? 16'hDEAD : pd[LAT-1];

  function automatic logic [15:0] exp_word(input logic [15:0] a);
    if (st_done && a == 16'h0040) return 16'hBEEF;
    return pattern(a);
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp_v);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%04h expected=%04h", tag, obs, exp_v);
    end
  endtask

  // Request must already be driven; cycle k is the k-th cycle after the grant edge.
  task automatic fill_check(input string tag, input logic is_d, input logic [15:0] addr,
                            input int pre_idle, input int stop_k, input int drop_k);
    logic en_e, dv_e, dn_e;
    logic [2:0]  w;
    logic [2:0]  iw;
    for (int p = 0; p < pre_idle; p++) begin
      @(negedge clk);
      chk1({tag, "/idle_en"},   bus.mem_en, 1'b0);
      chk1({tag, "/idle_idn"},  bus.i_done, 1'b0);
      chk1({tag, "/idle_ddn"},  bus.d_done, 1'b0);
    end
    for (int k = 1; k <= stop_k; k++) begin
      @(negedge clk);
      en_e = (k <= 8);
      dv_e = (k >= 1 + LAT);
      dn_e = (k == 8 + LAT);
      iw   = 3'(k - 1);
      w    = 3'(k - 1 - LAT);
      chk1({tag, "/en"}, bus.mem_en, en_e);
      chk1({tag, "/wr"}, bus.mem_wr, 1'b0);
      if (en_e) chk16({tag, "/addr"}, bus.mem_addr, {addr[15:4], iw, 1'b0});
      chk1({tag, "/i_dv"}, bus.i_data_valid, dv_e & ~is_d);
      chk1({tag, "/d_dv"}, bus.d_data_valid, dv_e & is_d);
      if (dv_e) begin
        chk16({tag, "/word"}, {13'd0, bus.fill_word}, {13'd0, w});
        chk16({tag, "/data"}, bus.fill_data, exp_word({addr[15:4], w, 1'b0}));
      end
      chk1({tag, "/i_done"},  bus.i_done,  dn_e & ~is_d);
      chk1({tag, "/d_done"},  bus.d_done,  dn_e & is_d);
      chk1({tag, "/i_stall"}, bus.i_stall, bus.i_req & ~(dn_e & ~is_d));
      chk1({tag, "/d_stall"}, bus.d_stall, bus.d_req & ~(dn_e & is_d));
      if (k == drop_k) begin
        if (is_d) bus.d_req = 1'b0;
        else      bus.i_req = 1'b0;
        #1;
        chk1({tag, "/drop_stall"}, is_d ? bus.d_stall : bus.i_stall, 1'b0);
      end
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    st_done     = 1'b0;
    spur        = 1'b0;
    rst         = 1'b1;
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_wr    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    #2 rst = 1'b0;
    spur = 1'b1;

    // Reset state: outputs low, fill_data follows mem_rdata
    @(negedge clk);
    chk1 ("rst/mem_en",  bus.mem_en, 1'b0);
    chk1 ("rst/mem_wr",  bus.mem_wr, 1'b0);
    chk16("rst/addr",    bus.mem_addr, 16'h0000);
    chk16("rst/wdata",   bus.mem_wdata, 16'h0000);
    chk1 ("rst/i_dv",    bus.i_data_valid, 1'b0);
    chk1 ("rst/d_dv",    bus.d_data_valid, 1'b0);
    chk16("rst/word",    {13'd0, bus.fill_word}, 16'h0000);
    chk1 ("rst/i_done",  bus.i_done, 1'b0);
    chk1 ("rst/d_done",  bus.d_done, 1'b0);
    chk1 ("rst/i_stall", bus.i_stall, 1'b0);
    chk1 ("rst/d_stall", bus.d_stall, 1'b0);
    chk16("rst/fdata",   bus.fill_data, 16'hDEAD);
    spur = 1'b0;
    rst  = 1'b1;
    @(negedge clk);

    // Single I fill from a mid-block miss address
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h1236;
    fill_check("ifill", 1'b0, 16'h1236, 0, 8 + LAT, 0);
    bus.i_req = 1'b0;
    @(negedge clk);
    chk1("ifill/after_en", bus.mem_en, 1'b0);

    // Fresh reset, then both request together: D, I, D, I
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h1100;
    bus.d_req  = 1'b1;
    bus.d_wr   = 1'b0;
    bus.d_addr = 16'h0200;
    fill_check("rr_d1", 1'b1, 16'h0200, 0, 8 + LAT, 0);
    fill_check("rr_i1", 1'b0, 16'h1100, 1, 8 + LAT, 0);
    fill_check("rr_d2", 1'b1, 16'h0200, 1, 8 + LAT, 0);
    fill_check("rr_i2", 1'b0, 16'h1100, 1, 8 + LAT, 0);
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    @(negedge clk);

    // Single-word store, then a D fill of the same block sees it
    bus.d_req   = 1'b1;
    bus.d_wr    = 1'b1;
    bus.d_addr  = 16'h0040;
    bus.d_wdata = 16'hBEEF;
    @(negedge clk);
    chk1 ("st/en",      bus.mem_en, 1'b1);
    chk1 ("st/wr",      bus.mem_wr, 1'b1);
    chk16("st/addr",    bus.mem_addr, 16'h0040);
    chk16("st/wdata",   bus.mem_wdata, 16'hBEEF);
    chk1 ("st/d_done",  bus.d_done, 1'b1);
    chk1 ("st/i_done",  bus.i_done, 1'b0);
    chk1 ("st/d_stall", bus.d_stall, 1'b0);
    bus.d_req = 1'b0;
    bus.d_wr  = 1'b0;
    st_done   = 1'b1;
    @(negedge clk);
    chk1("st/idle_en", bus.mem_en, 1'b0);
    bus.d_req = 1'b1;
    fill_check("dfill", 1'b1, 16'h0040, 0, 8 + LAT, 0);
    bus.d_req = 1'b0;

    // Stray returns while idle are ignored
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      spur = 1'b1;
      #1;
      chk1("spur/i_dv", bus.i_data_valid, 1'b0);
      chk1("spur/d_dv", bus.d_data_valid, 1'b0);
    end
    @(negedge clk);
    spur       = 1'b0;
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h4008;
    fill_check("spur_fill", 1'b0, 16'h4008, 0, 8 + LAT, 0);
    bus.i_req = 1'b0;

    // Reset after three returns, then a clean restart
    @(negedge clk);
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h2000;
    fill_check("mid", 1'b0, 16'h2000, 0, LAT + 3, 0);
    rst       = 1'b0;
    bus.i_req = 1'b0;
    #1;
    chk1 ("mid_rst/en",     bus.mem_en, 1'b0);
    chk1 ("mid_rst/i_dv",   bus.i_data_valid, 1'b0);
    chk16("mid_rst/addr",   bus.mem_addr, 16'h0000);
    chk16("mid_rst/word",   {13'd0, bus.fill_word}, 16'h0000);
    chk1 ("mid_rst/i_done", bus.i_done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.i_req = 1'b1;
    fill_check("post_rst", 1'b0, 16'h2000, 0, 8 + LAT, 0);
    bus.i_req = 1'b0;

    // Request withdrawn after two issues: fill still completes
    @(negedge clk);
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h3010;
    fill_check("drop", 1'b0, 16'h3010, 0, 8 + LAT, 2);
    @(negedge clk);
    chk1("drop/idle_en", bus.mem_en, 1'b0);
    chk1("drop/idle_dv", bus.i_data_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
